instr_fetch: RTL and testbench
==============================

# instr_fetch

Per-core instruction fetch unit sitting directly downstream of the shared instruction memory (IM). The top level instantiates `NUM_C` copies. Copy *i* drives `im_addr` onto IM address slice `[i*16 +:16]` and consumes IM data slice `[i*16 +:16]`. The unit assembles one- or two-word instructions (opcode plus optional operand word), hands them to the core control unit over a valid/ready handshake, and accepts PC redirects for taken jumps.

## Interface
Parameters:
- `RESET_PC`, 16'd0: PC loaded on reset.
- `ENDOP_CODE`, 16'd51: opcode that halts fetch.
- `LDAC_CODE`, 16'd5: two-word opcode.
- `JUMP_CODE`, 16'd46: two-word opcode.
- `JPNZ_CODE`, 16'd48: two-word opcode.
- `JPPZ_CODE`, 16'd62: two-word opcode.

Ports:
- `clk`  in  1  single clock. One clock; reset is synchronous and active-high.
- `rst`  in  1  synchronous, active-high reset.
- `im_addr`  out  16  address to this core's IM slice; equals the internal `pc` register.
- `im_data`  in  16  this core's IM data slice; holds `ram[addr]` one cycle after `addr` is presented.
- `instr_valid`  out  1  instruction bundle valid.
- `instr_ready`  in  1  control unit accepts the bundle.
- `instr_opcode`  out  16  opcode word.
- `instr_operand`  out  16  operand word; 0 for one-word instructions.
- `instr_pc`  out  16  address of the opcode word.
- `instr_two_word`  out  1  1 if the opcode is one of the four two-word codes.
- `redirect`  in  1  load a new PC; abort the fetch in progress.
- `redirect_pc`  in  16  target PC.
- `halted`  out  1  set after ENDOP is accepted.

## Operation
- States: ISSUE, OPC, OPW, OPND, DELIVER, HALT. All outputs are registered.
- ISSUE: `im_addr` = `pc`. Next state is OPC.
- OPC: `im_data` is valid.
  - Capture `instr_opcode` <= `im_data`, `instr_pc` <= `pc`, `pc` <= `pc`+1.
  - Two-word opcode: set `instr_two_word`, go to OPW.
  - Otherwise: `instr_operand` <= 0, go to DELIVER.
- OPW: `im_addr` = `pc` (operand address). Next state is OPND.
- OPND: `instr_operand` <= `im_data`, `pc` <= `pc`+1. Next state is DELIVER.
- DELIVER: `instr_valid` = 1. The bundle is held stable until `instr_ready`.
  - On `instr_ready` with opcode == `ENDOP_CODE`: go to HALT.
  - On `instr_ready` otherwise: go to ISSUE.
- HALT: `halted` = 1, `instr_valid` = 0, `pc` frozen. Exits only via `rst`.
- Redirect: `redirect` high in any state other than HALT sets `pc` <= `redirect_pc`, next state ISSUE, `instr_valid` <= 0.
  - A partially fetched instruction (OPC/OPW/OPND) is discarded.
  - Redirect and `instr_ready` in the same DELIVER cycle: the handshake completes (the instruction is consumed), then redirect takes effect. If that instruction is ENDOP, HALT wins and the redirect is ignored.
- Opcode classification is exact 16-bit equality against the parameters.
- `pc` arithmetic is 16-bit modulo: 16'hFFFF + 1 = 16'h0000, including the operand address.
- No range check against IM depth; out-of-range addresses are a software error.
- Reset: `pc` = `RESET_PC`, state = ISSUE. `instr_valid`, `instr_opcode`, `instr_operand`, `instr_pc`, `instr_two_word` and `halted` are all 0. Reset overrides every other input, including mid-fetch and in HALT.

## Timing
- Cycle 0 is the first cycle with `rst` low.
- One-word instruction: ISSUE at cycle 0, OPC at cycle 1, `instr_valid` high at cycle 2.
- Two-word instruction: ISSUE at 0, OPC at 1, OPW at 2, OPND at 3, `instr_valid` high at cycle 4.
- With `instr_ready` held high, throughput is one one-word instruction per 3 cycles and one two-word instruction per 5 cycles.
- Accept occurs in the cycle where `instr_valid` && `instr_ready`. `instr_valid` is low in the following cycle, which is ISSUE of the next PC.
- Redirect sampled in cycle t: `im_addr` = `redirect_pc` in cycle t+1. The new instruction is valid at t+3 (one-word) or t+5 (two-word).
- `instr_ready` while `instr_valid` is low has no effect.

## Test plan
- Reset with `ram[0]`=64 (MVCID): `im_addr` = 0 at cycles 0–1, then 1. At cycle 2: `instr_valid`=1, opcode 64, operand 0, `instr_pc` 0, `instr_two_word` 0.
- `ram[2]`=5, `ram[3]`=7 (LDAC 7) reached after a redirect to 2: `im_addr` goes 2, 2, 3, 3. `instr_valid` rises at redirect+5 with opcode 5, operand 7, `instr_pc` 2, `instr_two_word` 1. The next fetch address is 4.
- Backpressure: `instr_ready` low for 5 cycles during DELIVER. The bundle and `im_addr` stay unchanged. Accepted on the 6th cycle; next `im_addr` is the following instruction's address.
- `JPNZ 66` at 169: accept with `redirect`=1, `redirect_pc`=66 in the same cycle. Next cycle `im_addr`=66 and no instruction from 171 is ever valid. Separately, a redirect asserted during OPW discards the operand and nothing is delivered.
- `ram[216]`=51 (ENDOP): delivered with `instr_pc` 216. After accept, `halted`=1 and `im_addr` is frozen at 217. `redirect` is ignored. A 1-cycle `rst` clears `halted` and restarts at `RESET_PC`.
- `rst` asserted in OPND: the next cycle shows all outputs 0, `im_addr`=`RESET_PC`, state ISSUE. `pc` 16'hFFFF with a two-word opcode: operand is fetched from address 0.

Source files
------------

// File: rtl/instr_fetch.sv
// Per-core instruction fetch unit: assembles one- or two-word instructions from
// this core's instruction memory slice and delivers them over valid/ready.
module instr_fetch #(
  parameter logic [15:0] RESET_PC   = 16'd0,
  parameter logic [15:0] ENDOP_CODE = 16'd51,
  parameter logic [15:0] LDAC_CODE  = 16'd5,
  parameter logic [15:0] JUMP_CODE  = 16'd46,
  parameter logic [15:0] JPNZ_CODE  = 16'd48,
  parameter logic [15:0] JPPZ_CODE  = 16'd62
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] im_addr,
  input  logic [15:0] im_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [15:0] instr_opcode,
  output logic [15:0] instr_operand,
  output logic [15:0] instr_pc,
  output logic        instr_two_word,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        halted
);

  typedef enum logic [2:0] {
    S_ISSUE   = 3'd0,
    S_OPC     = 3'd1,
    S_OPW     = 3'd2,
    S_OPND    = 3'd3,
    S_DELIVER = 3'd4,
    S_HALT    = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_pc;
  logic        r_valid;
  logic [15:0] r_opcode;
  logic [15:0] r_operand;
  logic [15:0] r_instr_pc;
  logic        r_two_word;
  logic        r_halted;

  logic        w_two_word;
  logic        w_accept;
  logic        w_accept_endop;
  logic        w_redirect_take;

  assign w_two_word = (im_data == LDAC_CODE) || (im_data == JUMP_CODE) ||
                      (im_data == JPNZ_CODE) || (im_data == JPPZ_CODE);
  assign w_accept       = (r_state == S_DELIVER) && instr_ready;
  assign w_accept_endop = w_accept && (r_opcode == ENDOP_CODE);
  // A halting accept beats a same-cycle redirect; HALT ignores redirects entirely.
  assign w_redirect_take = redirect && (r_state != S_HALT) && !w_accept_endop;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_ISSUE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state selection.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_ISSUE:   w_next = S_OPC;
      S_OPC:     w_next = w_two_word ? S_OPW : S_DELIVER;
      S_OPW:     w_next = S_OPND;
      S_OPND:    w_next = S_DELIVER;
      S_DELIVER: begin
        if (instr_ready) begin
          w_next = (r_opcode == ENDOP_CODE) ? S_HALT : S_ISSUE;
        end else begin
          w_next = S_DELIVER;
        end
      end
      S_HALT:    w_next = S_HALT;
      default:   w_next = S_ISSUE;
    endcase
    if (w_redirect_take) begin
      w_next = S_ISSUE;
    end else begin
      w_next = w_next;
    end
  end

  // PC and instruction bundle registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc       <= RESET_PC;
      r_valid    <= 1'b0;
      r_opcode   <= 16'd0;
      r_operand  <= 16'd0;
      r_instr_pc <= 16'd0;
      r_two_word <= 1'b0;
      r_halted   <= 1'b0;
    end else if (w_redirect_take) begin
      r_pc    <= redirect_pc;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        S_OPC: begin
          r_opcode   <= im_data;
          r_instr_pc <= r_pc;
          r_pc       <= r_pc + 16'd1;
          r_two_word <= w_two_word;
          if (!w_two_word) begin
            r_operand <= 16'd0;
            r_valid   <= 1'b1;
          end
        end
        S_OPND: begin
          r_operand <= im_data;
          r_pc      <= r_pc + 16'd1;
          r_valid   <= 1'b1;
        end
        S_DELIVER: begin
          if (instr_ready) begin
            r_valid <= 1'b0;
            if (r_opcode == ENDOP_CODE) begin
              r_halted <= 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign im_addr        = r_pc;
  assign instr_valid    = r_valid;
  assign instr_opcode   = r_opcode;
  assign instr_operand  = r_operand;
  assign instr_pc       = r_instr_pc;
  assign instr_two_word = r_two_word;
  assign halted         = r_halted;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a one-cycle-latency memory model.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] im_addr;
  logic [15:0] im_data = 16'd0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [15:0] instr_opcode;
  logic [15:0] instr_operand;
  logic [15:0] instr_pc;
  logic        instr_two_word;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'd0;
  logic        halted;

  logic [15:0] ram [0:65535];
  int compared = 0;
  int mismatched = 0;

  instr_fetch dut (
    .clk(clk), .rst(rst), .im_addr(im_addr), .im_data(im_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_opcode(instr_opcode), .instr_operand(instr_operand),
    .instr_pc(instr_pc), .instr_two_word(instr_two_word),
    .redirect(redirect), .redirect_pc(redirect_pc), .halted(halted)
  );

  always #5 clk = ~clk;

  always @(posedge clk) im_data <= ram[im_addr];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_bundle(input string tag, input logic [15:0] op, input logic [15:0] opnd,
                            input logic [15:0] pc, input logic tw);
    chk({tag, ".valid"}, {31'd0, instr_valid}, 32'd1);
    chk({tag, ".opcode"}, {16'd0, instr_opcode}, {16'd0, op});
    chk({tag, ".operand"}, {16'd0, instr_operand}, {16'd0, opnd});
    chk({tag, ".pc"}, {16'd0, instr_pc}, {16'd0, pc});
    chk({tag, ".two_word"}, {31'd0, instr_two_word}, {31'd0, tw});
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) ram[i] = 16'd0;
    ram[0]      = 16'd64;
    ram[1]      = 16'd46;
    ram[2]      = 16'd5;
    ram[3]      = 16'd7;
    ram[66]     = 16'd5;
    ram[67]     = 16'h1234;
    ram[169]    = 16'd48;
    ram[170]    = 16'd66;
    ram[171]    = 16'd64;
    ram[216]    = 16'd51;
    ram[16'hFFFF] = 16'd62;

    // Reset and first one-word fetch
    step();
    rst = 1'b0;
    chk("c0.addr", {16'd0, im_addr}, 32'd0);
    chk("c0.valid", {31'd0, instr_valid}, 32'd0);
    chk("c0.halted", {31'd0, halted}, 32'd0);
    chk("c0.opcode", {16'd0, instr_opcode}, 32'd0);
    step();
    chk("c1.addr", {16'd0, im_addr}, 32'd0);
    chk("c1.valid", {31'd0, instr_valid}, 32'd0);
    step();
    chk_bundle("mvcid", 16'd64, 16'd0, 16'd0, 1'b0);
    chk("c2.addr", {16'd0, im_addr}, 32'd1);

    // Backpressure: five more cycles with ready low
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp.valid", {31'd0, instr_valid}, 32'd1);
      chk("bp.opcode", {16'd0, instr_opcode}, 32'd64);
      chk("bp.addr", {16'd0, im_addr}, 32'd1);
    end
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    chk("acc.valid", {31'd0, instr_valid}, 32'd0);
    chk("acc.addr", {16'd0, im_addr}, 32'd1);

    // Redirect to 2 and fetch LDAC 7
    redirect = 1'b1; redirect_pc = 16'd2;
    step();
    redirect = 1'b0;
    chk("ldac.a0", {16'd0, im_addr}, 32'd2);
    chk("ldac.v0", {31'd0, instr_valid}, 32'd0);
    step(); chk("ldac.a1", {16'd0, im_addr}, 32'd2);
    step(); chk("ldac.a2", {16'd0, im_addr}, 32'd3);
    step(); chk("ldac.a3", {16'd0, im_addr}, 32'd3);
    chk("ldac.v3", {31'd0, instr_valid}, 32'd0);
    step();
    chk_bundle("ldac", 16'd5, 16'd7, 16'd2, 1'b1);
    chk("ldac.next", {16'd0, im_addr}, 32'd4);

    // Accept together with redirect to 169
    instr_ready = 1'b1; redirect = 1'b1; redirect_pc = 16'd169;
    step();
    instr_ready = 1'b0; redirect = 1'b0;
    chk("r169.addr", {16'd0, im_addr}, 32'd169);
    chk("r169.valid", {31'd0, instr_valid}, 32'd0);
    step(); step(); step(); step();
    chk_bundle("jpnz", 16'd48, 16'd66, 16'd169, 1'b1);

    // Accept JPNZ with redirect to 66 in the same cycle
    instr_ready = 1'b1; redirect = 1'b1; redirect_pc = 16'd66;
    step();
    instr_ready = 1'b0; redirect = 1'b0;
    chk("r66.addr", {16'd0, im_addr}, 32'd66);
    chk("r66.valid", {31'd0, instr_valid}, 32'd0);
    step();
    step();
    chk("opw.addr", {16'd0, im_addr}, 32'd67);
    // Redirect during OPW discards the operand
    redirect = 1'b1; redirect_pc = 16'd216;
    step();
    redirect = 1'b0;
    chk("r216.addr", {16'd0, im_addr}, 32'd216);
    chk("r216.valid", {31'd0, instr_valid}, 32'd0);
    step();
    chk("abort.valid", {31'd0, instr_valid}, 32'd0);
    step();
    chk_bundle("endop", 16'd51, 16'd0, 16'd216, 1'b0);
    chk("endop.addr", {16'd0, im_addr}, 32'd217);

    // Accept ENDOP with a competing redirect: halt wins
    instr_ready = 1'b1; redirect = 1'b1; redirect_pc = 16'd300;
    step();
    instr_ready = 1'b0;
    chk("halt.halted", {31'd0, halted}, 32'd1);
    chk("halt.valid", {31'd0, instr_valid}, 32'd0);
    chk("halt.addr", {16'd0, im_addr}, 32'd217);
    step(); step();
    chk("halt2.addr", {16'd0, im_addr}, 32'd217);
    chk("halt2.halted", {31'd0, halted}, 32'd1);
    chk("halt2.valid", {31'd0, instr_valid}, 32'd0);
    redirect = 1'b0;

    // One-cycle reset leaves HALT
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rh.halted", {31'd0, halted}, 32'd0);
    chk("rh.addr", {16'd0, im_addr}, 32'd0);
    step(); step();
    chk_bundle("rh.mvcid", 16'd64, 16'd0, 16'd0, 1'b0);
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    chk("rh.issue", {16'd0, im_addr}, 32'd1);
    step(); step(); step();
    chk("opnd.addr", {16'd0, im_addr}, 32'd2);
    chk("opnd.opcode", {16'd0, instr_opcode}, 32'd46);

    // Reset asserted in OPND
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("ro.addr", {16'd0, im_addr}, 32'd0);
    chk("ro.valid", {31'd0, instr_valid}, 32'd0);
    chk("ro.opcode", {16'd0, instr_opcode}, 32'd0);
    chk("ro.operand", {16'd0, instr_operand}, 32'd0);
    chk("ro.pc", {16'd0, instr_pc}, 32'd0);
    chk("ro.tw", {31'd0, instr_two_word}, 32'd0);
    chk("ro.halted", {31'd0, halted}, 32'd0);

    // PC wrap: two-word opcode at FFFF takes its operand from 0
    redirect = 1'b1; redirect_pc = 16'hFFFF;
    step();
    redirect = 1'b0;
    chk("wrap.a0", {16'd0, im_addr}, 32'h0000FFFF);
    step(); step();
    chk("wrap.opw", {16'd0, im_addr}, 32'd0);
    step(); step();
    chk_bundle("wrap", 16'd62, 16'd64, 16'hFFFF, 1'b1);
    chk("wrap.next", {16'd0, im_addr}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
